fib_seq_ctrl: RTL

FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

---
 rtl/fib_pkg.sv | 27 ++
 rtl/fib_seq_ctrl_if.sv | 53 +++++
 rtl/fib_seq_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: FSM state encoding,
// register-bank addresses of the two working registers and the default
// largest index whose Fibonacci number still fits in 32 bits.
package fib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT_A = 3'd1,
        ST_INIT_B = 3'd2,
        ST_LOOP   = 3'd3,
        ST_FETCH  = 3'd4,
        ST_DONE   = 3'd5
    } fib_state_e;

    localparam logic [4:0] FIB_REG_A = 5'd1;
    localparam logic [4:0] FIB_REG_B = 5'd2;

    // F(47) = 0xB11924E1 is the last value that fits in 32 bits unsigned.
    localparam int FIB_N_MAX_DEFAULT = 47;

    // Maps the one-bit "older register" pointer onto a bank address:
    // 0 selects REG_A, 1 selects REG_B.
    function automatic logic [4:0] fib_reg_sel(input logic sel_b);
        return sel_b ? FIB_REG_B : FIB_REG_A;
    endfunction

endpackage

// File: rtl/fib_seq_ctrl_if.sv
// Bundle of the request/response handshake and the register-bank port of
// the Fibonacci sequencer. The slave modport is the sequencer's view; the
// master modport is the view of whoever issues requests and hosts the bank.
interface fib_seq_ctrl_if;

    logic        start;
    logic [5:0]  n;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;

    logic        rf_write_en;
    logic [4:0]  rf_write_dir;
    logic [31:0] rf_write_data;
    logic [4:0]  rf_read_dir1;
    logic [4:0]  rf_read_dir2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;

    modport master (
        output start,
        output n,
        input  busy,
        input  done,
        input  err,
        input  result,
        input  rf_write_en,
        input  rf_write_dir,
        input  rf_write_data,
        input  rf_read_dir1,
        input  rf_read_dir2,
        output rf_read_data1,
        output rf_read_data2
    );

    modport slave (
        input  start,
        input  n,
        output busy,
        output done,
        output err,
        output result,
        output rf_write_en,
        output rf_write_dir,
        output rf_write_data,
        output rf_read_dir1,
        output rf_read_dir2,
        input  rf_read_data1,
        input  rf_read_data2
    );

endinterface

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer. Computes F(n) by ping-ponging two registers of an
// external register bank: each LOOP cycle reads both, writes their sum over
// the older one and flips the older pointer, so the newest value always
// sits in the non-older register. Indices above FIB_N_MAX are rejected with
// err at once, without touching the bank.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int FIB_N_MAX = FIB_N_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          arst_n,
    fib_seq_ctrl_if.slave bus
);

    localparam logic [6:0] N_MAX_W = 7'(FIB_N_MAX);

    fib_state_e  state_q;
    fib_state_e  state_d;

    logic [5:0]  n_q;
    logic [5:0]  k_q;
    logic        older_q;
    logic [31:0] result_q;
    logic        err_q;

    logic        n_too_big;
    logic        busy_c;
    logic        done_c;
    logic        we_c;
    logic [4:0]  wdir_c;
    logic [31:0] wdata_c;
    logic [4:0]  rdir1_c;
    logic [4:0]  rdir2_c;

    assign n_too_big = {1'b0, bus.n} > N_MAX_W;

    // State register; reset drops straight back to IDLE and aborts a run.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; every bank port output idles at zero.
    always_comb begin
        state_d = state_q;
        busy_c  = 1'b1;
        done_c  = 1'b0;
        we_c    = 1'b0;
        wdir_c  = 5'd0;
        wdata_c = 32'd0;
        rdir1_c = 5'd0;
        rdir2_c = 5'd0;
        case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    state_d = n_too_big ? ST_DONE : ST_INIT_A;
                end
            end
            ST_INIT_A: begin
                we_c    = 1'b1;
                wdir_c  = FIB_REG_A;
                state_d = ST_INIT_B;
            end
            ST_INIT_B: begin
                we_c    = 1'b1;
                wdir_c  = FIB_REG_B;
                wdata_c = 32'd1;
                state_d = (n_q >= 6'd2) ? ST_LOOP : ST_FETCH;
            end
            ST_LOOP: begin
                rdir1_c = FIB_REG_A;
                rdir2_c = FIB_REG_B;
                we_c    = 1'b1;
                wdir_c  = fib_reg_sel(older_q);
                wdata_c = bus.rf_read_data1 + bus.rf_read_data2;
                if (k_q + 6'd1 == n_q) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rdir1_c = (n_q == 6'd0) ? FIB_REG_A : fib_reg_sel(~older_q);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_c  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run bookkeeping: capture n on accept, walk the counter and older
    // pointer through the loop, latch the newest value during FETCH.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            n_q      <= 6'd0;
            k_q      <= 6'd0;
            older_q  <= 1'b0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        n_q      <= bus.n;
                        err_q    <= n_too_big;
                        result_q <= 32'd0;
                    end
                end
                ST_INIT_B: begin
                    older_q <= 1'b0;
                    k_q     <= 6'd1;
                end
                ST_LOOP: begin
                    older_q <= ~older_q;
                    k_q     <= k_q + 6'd1;
                end
                ST_FETCH: begin
                    result_q <= bus.rf_read_data1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
    assign bus.err           = err_q;
    assign bus.result        = result_q;
    assign bus.rf_write_en   = we_c;
    assign bus.rf_write_dir  = wdir_c;
    assign bus.rf_write_data = wdata_c;
    assign bus.rf_read_dir1  = rdir1_c;
    assign bus.rf_read_dir2  = rdir2_c;

endmodule
